// File: rtl/fifo_burst_reader_pkg.sv
// fifo_burst_reader_pkg: shared constants and state encoding for the FIFO
// burst reader and its output buffer.
package fifo_burst_reader_pkg;

    // Default widths and abort threshold used when the top is not overridden.
    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_LEN_WIDTH      = 5;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

    // Output buffer occupancy type and its depth (two entries).
    typedef logic [1:0] obuf_cnt_t;
    localparam obuf_cnt_t OBUF_DEPTH = 2'd2;

    // Controller state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_BURST = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/fifo_burst_reader_obuf.sv
// fifo_burst_reader_obuf: two-entry in-order valid/ready buffer carrying
// {last, data}. The caller only pushes while the registered count is below
// the depth, so a push never meets a full buffer.
module fifo_burst_reader_obuf
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  push_last_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output obuf_cnt_t             count_o
);

    logic [DATA_WIDTH:0] head_q, head_d;
    logic [DATA_WIDTH:0] tail_q, tail_d;
    obuf_cnt_t           cnt_q, cnt_d;
    logic                pop;
    logic [DATA_WIDTH:0] push_word;

    assign push_word = {push_last_i, push_data_i};
    assign pop       = (cnt_q != 2'd0) && ready_i;
    assign valid_o   = (cnt_q != 2'd0);
    assign data_o    = head_q[DATA_WIDTH-1:0];
    assign last_o    = head_q[DATA_WIDTH];
    assign count_o   = cnt_q;

    // Next-state for the head/tail slots; the head always holds the oldest word.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push_i) begin
                    head_d = push_word;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop) begin
                    head_d = push_word;
                end else if (push_i) begin
                    tail_d = push_word;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
    end

    // Buffer registers; reset empties the buffer and clears the presented word.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a programmed number of words from a first-word-
// fall-through FIFO and streams them out through a two-entry buffer, tagging
// the final word with m_last.
// Optional mid-burst empty timeout: define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH      = DEF_LEN_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    obuf_cnt_t            buf_cnt;
    logic                 rd_en;
    logic                 drain_done;
    logic                 empty_stall;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            error_q, error_d;
    logic            to_hit;

    assign to_hit = empty_stall && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign error  = error_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign error          = 1'b0;
`endif

    // Pops are gated by reset so an in-flight burst stops popping immediately.
    assign rd_en = !reset && (state_q == ST_BURST) && !fifo_empty &&
                   (rem_q != '0) && (buf_cnt < OBUF_DEPTH);
    assign fifo_rd_en  = rd_en;
    assign empty_stall = (state_q == ST_BURST) && fifo_empty && (rem_q != '0);

    // The buffer is drained once it is empty or its last word leaves this cycle.
    assign drain_done = (buf_cnt == 2'd0) ||
                        ((buf_cnt == 2'd1) && m_valid && m_ready);

    assign busy = busy_q;
    assign done = done_q;

    fifo_burst_reader_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (rd_en),
        .push_last_i (rem_q == LEN_WIDTH'(1)),
        .push_data_i (fifo_data),
        .ready_i     (m_ready),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .last_o      (m_last),
        .count_o     (buf_cnt)
    );

    // Controller next-state: burst sequencing, word countdown and completion.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        error_d  = error_q;
        to_cnt_d = empty_stall ? (to_cnt_q + TO_W'(1)) : '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    if (burst_len != '0) begin
                        rem_d   = burst_len;
                        busy_d  = 1'b1;
                        state_d = ST_BURST;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (rd_en) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = ST_FLUSH;
                    end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                end else if (to_hit) begin
                    error_d  = 1'b1;
                    rem_d    = '0;
                    to_cnt_d = '0;
                    state_d  = ST_FLUSH;
`endif
                end else if (rem_q == '0) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (drain_done) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            error_q  <= 1'b0;
            to_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            error_q  <= error_d;
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

endmodule
